// File: rtl/dma_snd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// Module   : dma_snd_seq
// Brief    : DMA sound frame sequencer - register file, fetch FSM, shifter load strobe
// Revision : 1.0 - initial release
// ==========================================================================
module dma_snd_seq (
  input  logic        clk32,
  input  logic        resb,
  input  logic        CS,
  input  logic [5:1]  A,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RW,
  input  logic        SREQ,
  input  logic        SLOT,
  output logic [23:1] SADDR,
  output logic        SLOAD_N,
  output logic        SINT,
  output logic        SACTIVE
);

  localparam logic [5:1] c_A_CTRL   = 5'h00;
  localparam logic [5:1] c_A_ST_HI  = 5'h01;
  localparam logic [5:1] c_A_ST_MID = 5'h02;
  localparam logic [5:1] c_A_ST_LO  = 5'h03;
  localparam logic [5:1] c_A_CN_HI  = 5'h04;
  localparam logic [5:1] c_A_CN_MID = 5'h05;
  localparam logic [5:1] c_A_CN_LO  = 5'h06;
  localparam logic [5:1] c_A_EN_HI  = 5'h07;
  localparam logic [5:1] c_A_EN_MID = 5'h08;
  localparam logic [5:1] c_A_EN_LO  = 5'h09;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ADDR = 3'd2,
    S_LOAD = 3'd3,
    S_STEP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sub;
  logic        w_sub_nxt;

  logic        r_cs_d;
  logic        r_en;
  logic        r_loop;
  logic [23:1] r_start_w;
  logic [23:1] r_end_w;
  logic [23:1] r_start_a;
  logic [23:1] r_end_a;
  logic [23:1] r_cnt;
  logic [23:1] r_fetch;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_rise;
  logic        w_loop_eff;
  logic        w_en_nxt;
  logic        w_frame_end;
  logic        w_restart;
  logic [23:1] w_cnt_inc;
  logic [7:0]  w_rd_byte;
  logic        w_unused;

  assign w_unused   = ^DIN[15:8];
  assign w_wr       = CS && !RW && !r_cs_d;
  assign w_wr_ctrl  = w_wr && (A == c_A_CTRL);
  assign w_rise     = w_wr_ctrl && DIN[0] && !r_en;
  assign w_cnt_inc  = r_cnt + 23'd1;
  assign w_loop_eff = w_wr_ctrl ? DIN[1] : r_loop;

  // An empty frame (start == end) is detected in the first enabled IDLE clock
  assign w_frame_end = ((r_state == S_STEP) && (w_cnt_inc == r_end_a)) ||
                       ((r_state == S_IDLE) && r_en && (r_cnt == r_end_a));
  assign w_restart   = w_frame_end && w_loop_eff;

  always_comb begin
    w_en_nxt = r_en;
    if (w_wr_ctrl) begin
      w_en_nxt = DIN[0];
    end else if (w_frame_end && !r_loop) begin
      w_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_state <= S_IDLE;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = 1'b0;
    SLOAD_N     = 1'b1;
    SINT        = w_frame_end;
    SADDR       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_en && !w_frame_end) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!r_en) w_state_nxt = S_IDLE;
        else if (SLOT && SREQ) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        SADDR     = r_fetch;
        w_sub_nxt = !r_sub;
        if (r_sub) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        SADDR     = r_fetch;
        SLOAD_N   = 1'b0;
        w_sub_nxt = !r_sub;
        if (r_sub) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        w_state_nxt = w_en_nxt ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_cs_d    <= 1'b0;
      r_en      <= 1'b0;
      r_loop    <= 1'b0;
      r_start_w <= '0;
      r_end_w   <= '0;
      r_start_a <= '0;
      r_end_a   <= '0;
      r_cnt     <= '0;
      r_fetch   <= '0;
    end else begin
      r_cs_d <= CS;
      r_en   <= w_en_nxt;
      r_loop <= w_loop_eff;
      if (w_wr) begin
        case (A)
          c_A_ST_HI:  r_start_w[23:16] <= DIN[7:0];
          c_A_ST_MID: r_start_w[15:8]  <= DIN[7:0];
          c_A_ST_LO:  r_start_w[7:1]   <= DIN[7:1];
          c_A_EN_HI:  r_end_w[23:16]   <= DIN[7:0];
          c_A_EN_MID: r_end_w[15:8]    <= DIN[7:0];
          c_A_EN_LO:  r_end_w[7:1]     <= DIN[7:1];
          default: ;
        endcase
      end
      // Enable rising and loop restart both take the CPU-written frame bounds
      if (w_rise || w_restart) begin
        r_start_a <= r_start_w;
        r_end_a   <= r_end_w;
        r_cnt     <= r_start_w;
      end else if (r_state == S_STEP) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == S_WAIT) r_fetch <= r_cnt;
    end
  end

  always_comb begin
    w_rd_byte = 8'h00;
    case (A)
      c_A_CTRL:   w_rd_byte = {6'b000000, r_loop, r_en};
      c_A_ST_HI:  w_rd_byte = r_start_w[23:16];
      c_A_ST_MID: w_rd_byte = r_start_w[15:8];
      c_A_ST_LO:  w_rd_byte = {r_start_w[7:1], 1'b0};
      c_A_CN_HI:  w_rd_byte = r_cnt[23:16];
      c_A_CN_MID: w_rd_byte = r_cnt[15:8];
      c_A_CN_LO:  w_rd_byte = {r_cnt[7:1], 1'b0};
      c_A_EN_HI:  w_rd_byte = r_end_w[23:16];
      c_A_EN_MID: w_rd_byte = r_end_w[15:8];
      c_A_EN_LO:  w_rd_byte = {r_end_w[7:1], 1'b0};
      default:    w_rd_byte = 8'h00;
    endcase
    DOUT = (CS && RW) ? {8'h00, w_rd_byte} : 16'h0000;
  end

  assign SACTIVE = r_en;

endmodule
`default_nettype wire

// File: tb/tb_dma_snd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for dma_snd_seq.
module tb_dma_snd_seq;

  logic        clk32 = 1'b0;
  logic        resb  = 1'b1;
  logic        CS    = 1'b0;
  logic [5:1]  A     = 5'h00;
  logic [15:0] DIN   = 16'h0000;
  logic        RW    = 1'b1;
  logic        SREQ  = 1'b0;
  logic        SLOT  = 1'b0;
  logic [15:0] DOUT;
  logic [23:1] SADDR;
  logic        SLOAD_N;
  logic        SINT;
  logic        SACTIVE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk32 = ~clk32;

  dma_snd_seq dut (
    .clk32   (clk32),
    .resb    (resb),
    .CS      (CS),
    .A       (A),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .RW      (RW),
    .SREQ    (SREQ),
    .SLOT    (SLOT),
    .SADDR   (SADDR),
    .SLOAD_N (SLOAD_N),
    .SINT    (SINT),
    .SACTIVE (SACTIVE)
  );

  // Observers: fetch addresses at each load strobe, strobe widths, SINT pulses
  logic [23:1] m_addr[$];
  int          m_sint   = 0;
  int          m_len    = 0;
  int          m_badlen = 0;
  logic        m_prev   = 1'b1;

  always @(negedge clk32) begin
    if (SINT === 1'b1) m_sint++;
    if (SLOAD_N === 1'b0) begin
      if (m_prev) begin
        m_addr.push_back(SADDR);
        m_len = 0;
      end
      m_len++;
    end else if (!m_prev && m_len != 2) begin
      m_badlen++;
    end
    m_prev = SLOAD_N;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic clr_mon();
    @(posedge clk32);
    m_addr.delete();
    m_sint   = 0;
    m_len    = 0;
    m_badlen = 0;
  endtask

  task automatic wr(input logic [5:1] a, input logic [7:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = a; DIN = {8'h00, d};
    @(negedge clk32);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic rd(input logic [5:1] a, output logic [15:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b1; A = a;
    #1 d = DOUT;
    @(negedge clk32);
    CS = 1'b0;
  endtask

  task automatic rd_cnt(output logic [23:0] c);
    logic [15:0] d;
    rd(5'h04, d); c[23:16] = d[7:0];
    rd(5'h05, d); c[15:8]  = d[7:0];
    rd(5'h06, d); c[7:0]   = d[7:0];
  endtask

  task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
    wr(5'h01, s[23:16]); wr(5'h02, s[15:8]); wr(5'h03, s[7:0]);
    wr(5'h07, e[23:16]); wr(5'h08, e[15:8]); wr(5'h09, e[7:0]);
  endtask

  task automatic slot(input int gap);
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    repeat (gap) @(negedge clk32);
  endtask

  task automatic test_reset();
    #2 resb = 1'b0;
    repeat (3) @(negedge clk32);
    #1;
    n_checks++; if (SLOAD_N !== 1'b1) begin n_errors++; $display("FAIL reset_sload_n: got %b exp 1", SLOAD_N); end
    n_checks++; if (SINT !== 1'b0) begin n_errors++; $display("FAIL reset_sint: got %b exp 0", SINT); end
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL reset_sactive: got %b exp 0", SACTIVE); end
    n_checks++; if (SADDR !== 23'h0) begin n_errors++; $display("FAIL reset_saddr: got %h exp 000000", SADDR); end
    @(negedge clk32); resb = 1'b1;
    clr_mon();
    SREQ = 1'b1;
    slot(10);
    n_checks++; if (m_addr.size() != 0) begin n_errors++; $display("FAIL reset_idle_fetch: got %0d fetches exp 0", m_addr.size()); end
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL reset_idle_active: got %b exp 0", SACTIVE); end
  endtask

  task automatic test_regs();
    logic [15:0] d;
    logic [23:0] c;
    rd(5'h00, d);
    n_checks++; if (d !== 16'h0000) begin n_errors++; $display("FAIL regs_ctrl_reset: got %h exp 0000", d); end
    wr(5'h01, 8'hA5); rd(5'h01, d);
    n_checks++; if (d !== 16'h00A5) begin n_errors++; $display("FAIL regs_start_hi: got %h exp 00a5", d); end
    wr(5'h09, 8'hFF); rd(5'h09, d);
    n_checks++; if (d !== 16'h00FE) begin n_errors++; $display("FAIL regs_end_lo_bit0: got %h exp 00fe", d); end
    wr(5'h06, 8'h55); rd_cnt(c);
    n_checks++; if (c !== 24'h000000) begin n_errors++; $display("FAIL regs_counter_ro: got %h exp 000000", c); end
    rd(5'h0A, d);
    n_checks++; if (d !== 16'h0000) begin n_errors++; $display("FAIL regs_unmapped: got %h exp 0000", d); end
    @(negedge clk32); CS = 1'b0; RW = 1'b1; A = 5'h01; #1;
    n_checks++; if (DOUT !== 16'h0000) begin n_errors++; $display("FAIL regs_no_cs: got %h exp 0000", DOUT); end
  endtask

  task automatic test_single_frame();
    logic [23:1] exp_q[$];
    logic [23:0] c;
    set_frame(24'h010000, 24'h010004);
    clr_mon();
    SREQ = 1'b1;
    wr(5'h00, 8'h01);
    repeat (3) slot(62);
    exp_q = '{23'h008000, 23'h008001};
    n_checks++; if (m_addr != exp_q) begin n_errors++; $display("FAIL single_addrs: got %p exp %p", m_addr, exp_q); end
    n_checks++; if (m_badlen != 0) begin n_errors++; $display("FAIL single_strobe_len: got %0d bad exp 0", m_badlen); end
    n_checks++; if (m_sint != 1) begin n_errors++; $display("FAIL single_sint: got %0d exp 1", m_sint); end
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL single_sactive: got %b exp 0", SACTIVE); end
    rd_cnt(c);
    n_checks++; if (c !== 24'h010004) begin n_errors++; $display("FAIL single_counter: got %h exp 010004", c); end
  endtask

  task automatic test_loop();
    logic [23:1] exp_q[$];
    set_frame(24'h010000, 24'h010004);
    clr_mon();
    wr(5'h00, 8'h03);
    repeat (3) slot(10);
    set_frame(24'h020000, 24'h020004);
    repeat (3) slot(10);
    exp_q = '{23'h008000, 23'h008001, 23'h008000, 23'h008001, 23'h010000, 23'h010001};
    n_checks++; if (m_addr != exp_q) begin n_errors++; $display("FAIL loop_addrs: got %p exp %p", m_addr, exp_q); end
    n_checks++; if (m_sint != 3) begin n_errors++; $display("FAIL loop_sint: got %0d exp 3", m_sint); end
    n_checks++; if (SACTIVE !== 1'b1) begin n_errors++; $display("FAIL loop_sactive: got %b exp 1", SACTIVE); end
    wr(5'h00, 8'h00);
    repeat (3) @(negedge clk32);
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL loop_disable: got %b exp 0", SACTIVE); end
  endtask

  task automatic test_sreq_gate();
    set_frame(24'h010000, 24'h010008);
    clr_mon();
    wr(5'h00, 8'h01);
    SREQ = 1'b0;
    repeat (3) slot(10);
    n_checks++; if (m_addr.size() != 0) begin n_errors++; $display("FAIL sreq_blocked: got %0d fetches exp 0", m_addr.size()); end
    SREQ = 1'b1;
    slot(10);
    n_checks++;
    if (m_addr.size() != 1 || m_addr[0] !== 23'h008000) begin
      n_errors++; $display("FAIL sreq_resume: got %p exp '{008000}", m_addr);
    end
  endtask

  task automatic test_disable_in_load();
    logic [23:0] c;
    bit          seen;
    clr_mon();
    seen = 1'b0;
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (SLOAD_N === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk32);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL dis_load_timeout: got no strobe exp strobe within 20 clocks"); end
    wr(5'h00, 8'h00);
    repeat (6) @(negedge clk32);
    n_checks++;
    if (m_addr.size() != 1 || m_addr[0] !== 23'h008001) begin
      n_errors++; $display("FAIL dis_load_addr: got %p exp '{008001}", m_addr);
    end
    n_checks++; if (m_badlen != 0) begin n_errors++; $display("FAIL dis_load_len: got %0d bad exp 0", m_badlen); end
    n_checks++; if (m_sint != 0) begin n_errors++; $display("FAIL dis_load_sint: got %0d exp 0", m_sint); end
    rd_cnt(c);
    n_checks++; if (c !== 24'h010004) begin n_errors++; $display("FAIL dis_load_counter: got %h exp 010004", c); end
    slot(10);
    n_checks++; if (m_addr.size() != 1) begin n_errors++; $display("FAIL dis_load_idle: got %0d fetches exp 1", m_addr.size()); end
  endtask

  task automatic test_reenable();
    logic [23:0] c;
    wr(5'h00, 8'h01);
    rd_cnt(c);
    n_checks++; if (c !== 24'h010000) begin n_errors++; $display("FAIL reen_reload: got %h exp 010000", c); end
    slot(10);
    wr(5'h00, 8'h01);
    rd_cnt(c);
    n_checks++; if (c !== 24'h010002) begin n_errors++; $display("FAIL reen_no_reload: got %h exp 010002", c); end
    wr(5'h00, 8'h00);
  endtask

  task automatic test_empty_frame();
    logic [23:0] c;
    set_frame(24'h030000, 24'h030000);
    clr_mon();
    wr(5'h00, 8'h01);
    repeat (4) @(negedge clk32);
    slot(10);
    n_checks++; if (m_sint != 1) begin n_errors++; $display("FAIL empty_sint: got %0d exp 1", m_sint); end
    n_checks++; if (m_addr.size() != 0) begin n_errors++; $display("FAIL empty_fetch: got %0d fetches exp 0", m_addr.size()); end
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL empty_sactive: got %b exp 0", SACTIVE); end
    rd_cnt(c);
    n_checks++; if (c !== 24'h030000) begin n_errors++; $display("FAIL empty_counter: got %h exp 030000", c); end
  endtask

  task automatic test_eof_priority();
    logic [23:1] exp_q[$];
    set_frame(24'h010000, 24'h010002);
    clr_mon();
    wr(5'h00, 8'h01);
    repeat (2) @(negedge clk32);
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    repeat (3) @(negedge clk32);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = 5'h00; DIN = 16'h0003;
    #1;
    n_checks++; if (SINT !== 1'b1) begin n_errors++; $display("FAIL eof_align: got SINT %b exp 1", SINT); end
    @(negedge clk32); CS = 1'b0; RW = 1'b1;
    n_checks++; if (SACTIVE !== 1'b1) begin n_errors++; $display("FAIL eof_cpu_wins: got %b exp 1", SACTIVE); end
    slot(10);
    exp_q = '{23'h008000, 23'h008000};
    n_checks++; if (m_addr != exp_q) begin n_errors++; $display("FAIL eof_addrs: got %p exp %p", m_addr, exp_q); end
    n_checks++; if (m_sint != 2) begin n_errors++; $display("FAIL eof_sint: got %0d exp 2", m_sint); end
    wr(5'h00, 8'h00);
  endtask

  task automatic test_reset_in_load();
    bit seen;
    set_frame(24'h010000, 24'h010004);
    wr(5'h00, 8'h01);
    repeat (2) @(negedge clk32);
    seen = 1'b0;
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (SLOAD_N === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk32);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rst_load_timeout: got no strobe exp strobe within 20 clocks"); end
    CS = 1'b1; RW = 1'b1; A = 5'h00;
    #1 resb = 1'b0;
    #1;
    n_checks++; if (SLOAD_N !== 1'b1) begin n_errors++; $display("FAIL rst_load_sload_n: got %b exp 1", SLOAD_N); end
    n_checks++; if (DOUT !== 16'h0000) begin n_errors++; $display("FAIL rst_load_dout: got %h exp 0000", DOUT); end
    n_checks++; if (SACTIVE !== 1'b0) begin n_errors++; $display("FAIL rst_load_sactive: got %b exp 0", SACTIVE); end
    n_checks++; if (SINT !== 1'b0) begin n_errors++; $display("FAIL rst_load_sint: got %b exp 0", SINT); end
    CS = 1'b0;
    repeat (2) @(negedge clk32);
    resb = 1'b1;
    clr_mon();
    slot(10);
    n_checks++; if (m_addr.size() != 0) begin n_errors++; $display("FAIL rst_load_idle: got %0d fetches exp 0", m_addr.size()); end
    n_checks++; if (m_sint != 0) begin n_errors++; $display("FAIL rst_load_no_sint: got %0d exp 0", m_sint); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_single_frame();
    test_loop();
    test_sreq_gate();
    test_disable_in_load();
    test_reenable();
    test_empty_frame();
    test_eof_priority();
    test_reset_in_load();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
